// File: rtl/axil_apb_pkg.sv
// -----------------------------------------------------------------------------
// axil_apb_pkg
//   Shared definitions for the AXI4-Lite to APB bridge:
//     - bridge_state_t : FSM state encoding (IDLE / SETUP / ACCESS / RESP)
//     - AXI_RESP_*     : AXI response codes returned on s_bresp / s_rresp
//     - axi_resp_from_slverr() : maps the APB error flag onto an AXI response
// -----------------------------------------------------------------------------
package axil_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } bridge_state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   function automatic logic [1:0] axi_resp_from_slverr(input logic pslverr);
      return pslverr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
   endfunction

endpackage : axil_apb_pkg

// File: rtl/axil_to_apb_bridge.sv
// -----------------------------------------------------------------------------
// axil_to_apb_bridge
//   AXI4-Lite slave to APB master bridge. One AXI read or write is turned into
//   one APB SETUP/ACCESS transfer; the APB result is returned on R or B.
//   Only one transaction is ever in flight.
//
// Ports
//   clock, reset                 single clock, asynchronous active-high reset
//   s_aw* / s_w* / s_b*          AXI4-Lite write address / data / response
//   s_ar* / s_r*                 AXI4-Lite read address / data
//   out_paddr .. out_pstrb       APB request towards the downstream slave
//   out_pready/prdata/pslverr    APB completion from the downstream slave
// -----------------------------------------------------------------------------
module axil_to_apb_bridge
   import axil_apb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic              clock,
   input  logic              reset,

   // AXI4-Lite write address
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [ADDR_W-1:0] s_awaddr,
   input  logic [2:0]        s_awprot,
   // AXI4-Lite write data
   input  logic              s_wvalid,
   output logic              s_wready,
   input  logic [DATA_W-1:0] s_wdata,
   input  logic [STRB_W-1:0] s_wstrb,
   // AXI4-Lite write response
   output logic              s_bvalid,
   input  logic              s_bready,
   output logic [1:0]        s_bresp,
   // AXI4-Lite read address
   input  logic              s_arvalid,
   output logic              s_arready,
   input  logic [ADDR_W-1:0] s_araddr,
   input  logic [2:0]        s_arprot,
   // AXI4-Lite read data
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic [DATA_W-1:0] s_rdata,
   output logic [1:0]        s_rresp,

   // APB master
   output logic [ADDR_W-1:0] out_paddr,
   output logic              out_psel,
   output logic              out_penable,
   output logic [2:0]        out_pprot,
   output logic              out_pwrite,
   output logic [DATA_W-1:0] out_pwdata,
   output logic [STRB_W-1:0] out_pstrb,
   input  logic              out_pready,
   input  logic [DATA_W-1:0] out_prdata,
   input  logic              out_pslverr
);

   // ---------------------------------------------------------------------------
   // State and capture registers
   // ---------------------------------------------------------------------------
   bridge_state_t     state_q,   state_d;
   logic              last_wr_q, last_wr_d;   // direction of the most recent grant
   logic              write_q,   write_d;     // direction of the transfer in flight
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [2:0]        prot_q,    prot_d;
   logic [DATA_W-1:0] wdata_q,   wdata_d;
   logic [STRB_W-1:0] wstrb_q,   wstrb_d;
   logic [DATA_W-1:0] rdata_q,   rdata_d;
   logic [1:0]        resp_q,    resp_d;

   // ---------------------------------------------------------------------------
   // Request arbitration (only meaningful in IDLE)
   // A write needs both AW and W present; half a write is never accepted.
   // On a conflict the direction not granted last time wins, so a write is
   // granted first after reset (last_wr_q starts at 0).
   // ---------------------------------------------------------------------------
   logic wr_req;
   logic rd_req;
   logic grant_wr;
   logic grant_rd;

   assign wr_req   = s_awvalid & s_wvalid;
   assign rd_req   = s_arvalid;
   assign grant_wr = wr_req & (~rd_req | ~last_wr_q);
   assign grant_rd = rd_req & ~grant_wr;

   // ---------------------------------------------------------------------------
   // Process 1: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its _d, independent of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         last_wr_q <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         prot_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= AXI_RESP_OKAY;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         prot_q    <= prot_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Process 2: next-state and capture logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned here gets a default first (hold the current
   // value), so no path through the case statement can infer a latch.
   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      write_d   = write_q;
      addr_d    = addr_q;
      prot_d    = prot_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;

      unique case (state_q)
         ST_IDLE: begin
            if (grant_wr) begin
               write_d   = 1'b1;
               last_wr_d = 1'b1;
               addr_d    = s_awaddr;
               prot_d    = s_awprot;
               wdata_d   = s_wdata;
               wstrb_d   = s_wstrb;
               state_d   = ST_SETUP;
            end else if (grant_rd) begin
               // Reads present all-zero write data and strobes on APB.
               write_d   = 1'b0;
               last_wr_d = 1'b0;
               addr_d    = s_araddr;
               prot_d    = s_arprot;
               wdata_d   = '0;
               wstrb_d   = '0;
               state_d   = ST_SETUP;
            end
         end

         ST_SETUP: begin
            state_d = ST_ACCESS;
         end

         ST_ACCESS: begin
            // No timeout: the slave may stretch ACCESS indefinitely.
            if (out_pready) begin
               rdata_d = write_q ? '0 : out_prdata;
               resp_d  = axi_resp_from_slverr(out_pslverr);
               state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            if (write_q ? s_bready : s_rready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Process 3: output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      s_awready   = 1'b0;
      s_wready    = 1'b0;
      s_arready   = 1'b0;
      out_psel    = 1'b0;
      out_penable = 1'b0;
      s_bvalid    = 1'b0;
      s_rvalid    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Ready is a combinational function of valid; it is also forced
            // low while reset is held so nothing appears accepted during reset.
            s_awready = grant_wr & ~reset;
            s_wready  = grant_wr & ~reset;
            s_arready = grant_rd & ~reset;
         end
         ST_SETUP: begin
            out_psel = 1'b1;
         end
         ST_ACCESS: begin
            out_psel    = 1'b1;
            out_penable = 1'b1;
         end
         ST_RESP: begin
            s_bvalid = write_q;
            s_rvalid = ~write_q;
         end
         default: begin
            s_awready = 1'b0;
         end
      endcase
   end

   // APB request fields come straight from the capture registers, so they are
   // stable for the whole SETUP/ACCESS window.
   assign out_paddr  = addr_q;
   assign out_pprot  = prot_q;
   assign out_pwrite = write_q;
   assign out_pwdata = wdata_q;
   assign out_pstrb  = wstrb_q;

   // Response channels share the captured result.
   assign s_bresp = resp_q;
   assign s_rresp = resp_q;
   assign s_rdata = rdata_q;

endmodule : axil_to_apb_bridge

// File: tb/tb_axil_to_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_axil_to_apb_bridge
//   Self-checking bench for axil_to_apb_bridge. The bench plays both the AXI
//   master and the APB slave. Expected values come from a transaction-level
//   model: which direction is granted (round-robin on conflicts), what the APB
//   transfer must carry, and what response must come back.
// -----------------------------------------------------------------------------
module tb_axil_to_apb_bridge;

   logic        clock;
   logic        reset;

   logic        s_awvalid, s_awready;
   logic [31:0] s_awaddr;
   logic [2:0]  s_awprot;
   logic        s_wvalid, s_wready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_bvalid, s_bready;
   logic [1:0]  s_bresp;
   logic        s_arvalid, s_arready;
   logic [31:0] s_araddr;
   logic [2:0]  s_arprot;
   logic        s_rvalid, s_rready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;

   logic [31:0] out_paddr;
   logic        out_psel, out_penable;
   logic [2:0]  out_pprot;
   logic        out_pwrite;
   logic [31:0] out_pwdata;
   logic [3:0]  out_pstrb;
   logic        out_pready;
   logic [31:0] out_prdata;
   logic        out_pslverr;

   int checks = 0;
   int errors = 0;
   bit last_wr_m = 1'b0;   // model: direction of the last granted request

   axil_to_apb_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .s_awvalid  (s_awvalid),
      .s_awready  (s_awready),
      .s_awaddr   (s_awaddr),
      .s_awprot   (s_awprot),
      .s_wvalid   (s_wvalid),
      .s_wready   (s_wready),
      .s_wdata    (s_wdata),
      .s_wstrb    (s_wstrb),
      .s_bvalid   (s_bvalid),
      .s_bready   (s_bready),
      .s_bresp    (s_bresp),
      .s_arvalid  (s_arvalid),
      .s_arready  (s_arready),
      .s_araddr   (s_araddr),
      .s_arprot   (s_arprot),
      .s_rvalid   (s_rvalid),
      .s_rready   (s_rready),
      .s_rdata    (s_rdata),
      .s_rresp    (s_rresp),
      .out_paddr  (out_paddr),
      .out_psel   (out_psel),
      .out_penable(out_penable),
      .out_pprot  (out_pprot),
      .out_pwrite (out_pwrite),
      .out_pwdata (out_pwdata),
      .out_pstrb  (out_pstrb),
      .out_pready (out_pready),
      .out_prdata (out_prdata),
      .out_pslverr(out_pslverr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_apb(input string tag, input logic [31:0] addr, input logic [2:0] prot,
                            input bit wr, input logic [31:0] wdata, input logic [3:0] strb);
      check({tag, "_paddr"},  out_paddr,  addr);
      check({tag, "_pprot"},  out_pprot,  prot);
      check({tag, "_pwrite"}, out_pwrite, wr);
      check({tag, "_pwdata"}, out_pwdata, wdata);
      check({tag, "_pstrb"},  out_pstrb,  strb);
   endtask

   task automatic idle_inputs();
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      s_bready  = 0; s_rready = 0;
      out_pready = 0; out_pslverr = 0;
   endtask

   // One complete AXI transaction seen from both sides. Inputs change just
   // after a falling edge and outputs are sampled 1 time unit later.
   task automatic txn(input bit req_wr, input bit req_rd,
                      input logic [31:0] waddr, input logic [2:0] wprot,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic [31:0] raddr, input logic [2:0] rprot,
                      input int waits, input logic [31:0] prdata_fin,
                      input bit slverr, input int rdly);
      bit          g_wr;
      logic [31:0] e_addr, e_wdata, e_rdata;
      logic [2:0]  e_prot;
      logic [3:0]  e_strb;
      logic [1:0]  e_resp;

      g_wr      = (req_wr && req_rd) ? !last_wr_m : req_wr;
      last_wr_m = g_wr;
      e_addr  = g_wr ? waddr : raddr;
      e_prot  = g_wr ? wprot : rprot;
      e_wdata = g_wr ? wdata : 32'h0;
      e_strb  = g_wr ? wstrb : 4'h0;
      e_resp  = slverr ? 2'b10 : 2'b00;
      e_rdata = g_wr ? 32'h0 : prdata_fin;

      // Cycle T: request presented, accepted combinationally.
      @(negedge clock);
      s_awvalid = req_wr; s_wvalid = req_wr; s_awaddr = waddr; s_awprot = wprot;
      s_wdata = wdata; s_wstrb = wstrb;
      s_arvalid = req_rd; s_araddr = raddr; s_arprot = rprot;
      #1;
      check("awready_T", s_awready, g_wr);
      check("wready_T",  s_wready,  g_wr);
      check("arready_T", s_arready, !g_wr);
      check("psel_T",    out_psel,  1'b0);

      // T+1: SETUP. Scramble the AXI fields to prove the bridge captured them.
      @(negedge clock);
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      s_awaddr = $urandom; s_araddr = $urandom; s_wdata = $urandom; s_wstrb = 4'($urandom);
      #1;
      check("setup_psel",    out_psel,    1'b1);
      check("setup_penable", out_penable, 1'b0);
      check_apb("setup", e_addr, e_prot, g_wr, e_wdata, e_strb);

      // T+2 onward: ACCESS, slave inserts 'waits' wait states.
      for (int i = 0; i <= waits; i++) begin
         @(negedge clock);
         out_pready  = (i == waits);
         out_prdata  = (i == waits) ? prdata_fin : $urandom;
         out_pslverr = (i == waits) ? slverr : 1'($urandom);
         #1;
         check("access_psel",    out_psel,    1'b1);
         check("access_penable", out_penable, 1'b1);
         check_apb("access", e_addr, e_prot, g_wr, e_wdata, e_strb);
         check("access_bvalid",  s_bvalid,    1'b0);
         check("access_rvalid",  s_rvalid,    1'b0);
      end

      // RESP: response visible one cycle after pready. New requests are
      // offered while waiting and must not be accepted.
      @(negedge clock);
      out_pready = 0; out_prdata = $urandom; out_pslverr = 1'($urandom);
      s_arvalid = 1; s_awvalid = 1; s_wvalid = 1;
      for (int i = 0; i < rdly; i++) begin
         #1;
         check("hold_bvalid",  s_bvalid,  g_wr);
         check("hold_rvalid",  s_rvalid,  !g_wr);
         check("hold_resp",    g_wr ? s_bresp : s_rresp, e_resp);
         check("hold_rdata",   s_rdata,   e_rdata);
         check("hold_psel",    out_psel,  1'b0);
         check("hold_arready", s_arready, 1'b0);
         check("hold_awready", s_awready, 1'b0);
         @(negedge clock);
      end
      s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
      if (g_wr) s_bready = 1; else s_rready = 1;
      #1;
      check("resp_bvalid",  s_bvalid,    g_wr);
      check("resp_rvalid",  s_rvalid,    !g_wr);
      check("resp_resp",    g_wr ? s_bresp : s_rresp, e_resp);
      check("resp_rdata",   s_rdata,     e_rdata);
      check("resp_psel",    out_psel,    1'b0);
      check("resp_penable", out_penable, 1'b0);

      // Handshake done: back in IDLE.
      @(negedge clock);
      s_bready = 0; s_rready = 0;
      #1;
      check("done_bvalid", s_bvalid, 1'b0);
      check("done_rvalid", s_rvalid, 1'b0);
      check("done_psel",   out_psel, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      s_awaddr = 0; s_awprot = 0; s_wdata = 0; s_wstrb = 0;
      s_araddr = 0; s_arprot = 0; out_prdata = 0;

      // Reset state: every output low, even with requests offered.
      repeat (2) @(negedge clock);
      s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
      #1;
      check("rst_awready", s_awready, 1'b0);
      check("rst_arready", s_arready, 1'b0);
      check("rst_psel",    out_psel,  1'b0);
      check("rst_bvalid",  s_bvalid,  1'b0);
      check("rst_rvalid",  s_rvalid,  1'b0);
      check("rst_paddr",   out_paddr, 32'h0);
      check("rst_rdata",   s_rdata,   32'h0);
      @(negedge clock);
      idle_inputs();
      reset = 1'b0;
      last_wr_m = 1'b0;

      // First conflict after reset grants the write, the next one the read.
      txn(1, 1, 32'hA000_0010, 3'd1, 32'hCAFE_0001, 4'hF, 32'hB000_0020, 3'd2, 0, 32'h1111_2222, 0, 0);
      txn(1, 1, 32'hA000_0014, 3'd3, 32'hCAFE_0002, 4'h5, 32'hB000_0024, 3'd4, 0, 32'h3333_4444, 0, 0);

      // Read, pready in first ACCESS cycle.
      txn(0, 1, 32'h0, 3'd0, 32'h0, 4'h0, 32'h1000_0004, 3'd0, 0, 32'hDEAD_BEEF, 0, 0);
      // Write with 5 wait states.
      txn(1, 0, 32'h1000_0008, 3'd2, 32'h1234_5678, 4'h3, 32'h0, 3'd0, 5, 32'h5555_5555, 0, 0);
      // Read with slave error.
      txn(0, 1, 32'h0, 3'd0, 32'h0, 4'h0, 32'h2000_0000, 3'd5, 1, 32'hFFFF_FFFF, 1, 0);
      // Read with rready held low for 4 cycles.
      txn(0, 1, 32'h0, 3'd0, 32'h0, 4'h0, 32'h3000_0040, 3'd6, 0, 32'h0BAD_F00D, 0, 4);

      // AW without W for 10 cycles, then W without AW for 5: never accepted.
      @(negedge clock);
      s_awvalid = 1; s_awaddr = 32'h4000_0000;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("aw_only_awready", s_awready, 1'b0);
         check("aw_only_psel",    out_psel,  1'b0);
         @(negedge clock);
      end
      s_awvalid = 0; s_wvalid = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("w_only_wready", s_wready, 1'b0);
         check("w_only_psel",   out_psel, 1'b0);
         @(negedge clock);
      end
      s_wvalid = 0;

      // Reset asserted mid-ACCESS: outputs drop immediately.
      @(negedge clock);
      s_arvalid = 1; s_araddr = 32'h5000_0008; s_arprot = 3'd7;
      @(negedge clock);
      s_arvalid = 0;
      @(negedge clock);
      #1;
      check("pre_rst_penable", out_penable, 1'b1);
      reset = 1'b1;
      #1;
      check("mid_rst_psel",    out_psel,    1'b0);
      check("mid_rst_penable", out_penable, 1'b0);
      check("mid_rst_paddr",   out_paddr,   32'h0);
      check("mid_rst_pprot",   out_pprot,   3'd0);
      check("mid_rst_rvalid",  s_rvalid,    1'b0);
      check("mid_rst_arready", s_arready,   1'b0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      last_wr_m = 1'b0;
      txn(0, 1, 32'h0, 3'd0, 32'h0, 4'h0, 32'h0000_0000, 3'd0, 0, 32'h7777_8888, 0, 0);

      // Randomized transactions against the model.
      for (int n = 0; n < 40; n++) begin
         bit rw, rr;
         rw = 1'($urandom);
         rr = 1'($urandom);
         if (!rw && !rr) rr = 1;
         txn(rw, rr, $urandom, 3'($urandom), $urandom, 4'($urandom),
             $urandom, 3'($urandom), int'($urandom_range(0, 3)), $urandom,
             1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_axil_to_apb_bridge
